// File: rtl/econet_rx_frame_queue_if.sv
// Econet receive back-end bundle: bit-receiver strobes, station filter
// settings, external byte-buffer write port and the descriptor queue head.
// master = receiver/CPU side, slave = econet_rx_frame_queue.
// Handshake: a descriptor is transferred when desc_valid and desc_pop are
// both high in the same econet_clk cycle; desc_pop without desc_valid is
// ignored, and buf_we is a single-cycle write strobe with no back-pressure.
interface econet_rx_frame_queue_if #(
  parameter int BUF_AW     = 11,
  parameter int DESC_DEPTH = 4
);
  localparam int CW = $clog2(DESC_DEPTH + 1);

  logic [7:0]        rx_byte;
  logic              rx_byte_ready;
  logic              rx_frame_start;
  logic              rx_frame_end;
  logic [15:0]       rx_fcs;
  logic [15:0]       our_address;
  logic              promisc;

  logic              buf_we;
  logic [BUF_AW-1:0] buf_waddr;
  logic [7:0]        buf_wdata;

  logic              desc_valid;
  logic [BUF_AW-1:0] desc_start;
  logic [BUF_AW-1:0] desc_end;
  logic [BUF_AW:0]   desc_cnt;
  logic [31:0]       desc_address;
  logic [15:0]       desc_scout;
  logic              desc_pop;
  logic [CW-1:0]     desc_count;
  logic [7:0]        drop_count;
  logic [1:0]        dbg_state;

  modport master (
    output rx_byte, rx_byte_ready, rx_frame_start, rx_frame_end, rx_fcs,
           our_address, promisc, desc_pop,
    input  buf_we, buf_waddr, buf_wdata, desc_valid, desc_start, desc_end,
           desc_cnt, desc_address, desc_scout, desc_count, drop_count, dbg_state
  );

  modport slave (
    input  rx_byte, rx_byte_ready, rx_frame_start, rx_frame_end, rx_fcs,
           our_address, promisc, desc_pop,
    output buf_we, buf_waddr, buf_wdata, desc_valid, desc_start, desc_end,
           desc_cnt, desc_address, desc_scout, desc_count, drop_count, dbg_state
  );
endinterface

// File: rtl/econet_rx_frame_queue.sv
// Econet receive frame queue: writes received bytes into a circular byte
// buffer, filters frames by destination, queues accepted frames as
// descriptors and protects queued frames from overwrite until popped.
// Optional: define ECONET_BCAST_EN to also accept destination FF FF.
module econet_rx_frame_queue #(
  parameter int          BUF_AW     = 11,
  parameter int          DESC_DEPTH = 4,
  parameter logic [15:0] FCS_GOOD   = 16'hF0B8,
  parameter int          MIN_LEN    = 6
) (
  input  logic                   econet_clk,
  input  logic                   valid_rst,
  econet_rx_frame_queue_if.slave bus
);
  localparam int QAW  = (DESC_DEPTH > 1) ? $clog2(DESC_DEPTH) : 1;
  localparam int CW   = $clog2(DESC_DEPTH + 1);
  localparam int CNTW = BUF_AW + 1;
  // descriptor word: {start, end, cnt, header bytes 5..0}
  localparam int DW   = 3 * BUF_AW + 49;
  localparam logic [CNTW-1:0] MIN_LEN_C = CNTW'(MIN_LEN);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RX   = 2'd1;
  localparam logic [1:0] ST_OVR  = 2'd2;

  logic [1:0]        r_state;
  logic [BUF_AW-1:0] r_wptr;
  logic [BUF_AW-1:0] r_fstart;
  logic [CNTW-1:0]   r_cnt;
  logic [47:0]       r_hdr;
  logic [DW-1:0]     r_q [DESC_DEPTH];
  logic [QAW-1:0]    r_rd;
  logic [QAW-1:0]    r_wr;
  logic [CW-1:0]     r_count;
  logic [7:0]        r_drop;

  logic              w_in_frame, w_pop, w_bound_ok, w_byte_rx, w_hit, w_we, w_ovr;
  logic              w_hdr_cap, w_filter, w_bcast, w_good, w_full, w_end;
  logic              w_push, w_abort, w_drop, w_valid;
  logic [QAW-1:0]    w_rd_next;
  logic [DW-1:0]     w_head, w_next;
  logic [BUF_AW-1:0] w_bound, w_wptr_inc, w_wptr_after;
  logic [CNTW-1:0]   w_cnt_eff;
  logic [47:0]       w_hdr_eff;

  assign w_in_frame = (r_state != ST_IDLE);
  assign w_valid    = (r_count != '0);
  assign w_pop      = bus.desc_pop & w_valid;
  assign w_rd_next  = r_rd + QAW'(1);
  assign w_head     = r_q[r_rd];
  assign w_next     = r_q[w_rd_next];

  // Protection boundary follows a pop in the same cycle.
  assign w_bound_ok = w_pop ? (r_count > CW'(1)) : w_valid;
  assign w_bound    = w_pop ? w_next[DW-1 -: BUF_AW] : w_head[DW-1 -: BUF_AW];

  assign w_byte_rx  = (r_state == ST_RX) & bus.rx_byte_ready;
  assign w_hit      = w_byte_rx & w_bound_ok & (r_wptr == w_bound);
  assign w_we       = w_byte_rx & ~w_hit;
  assign w_ovr      = (r_state == ST_OVR) | w_hit;
  assign w_wptr_inc = r_wptr + {{(BUF_AW-1){1'b0}}, w_we};

  assign w_hdr_cap  = w_in_frame & bus.rx_byte_ready;
  assign w_cnt_eff  = (w_hdr_cap & ~(&r_cnt)) ? r_cnt + CNTW'(1) : r_cnt;

  // Header as it stands including a byte strobed this cycle.
  always_comb begin
    w_hdr_eff = r_hdr;
    for (int i = 0; i < 6; i++) begin
      if (w_hdr_cap && r_cnt == CNTW'(i)) w_hdr_eff[8*i +: 8] = bus.rx_byte;
    end
  end

`ifdef ECONET_BCAST_EN
  assign w_bcast = (w_hdr_eff[15:0] == 16'hFFFF);
`else
  assign w_bcast = 1'b0;
`endif

  assign w_filter = bus.promisc | w_bcast |
                    ((w_hdr_eff[7:0] == bus.our_address[7:0]) &
                     (w_hdr_eff[15:8] == bus.our_address[15:8]));
  assign w_good   = (bus.rx_fcs == FCS_GOOD) & (w_cnt_eff >= MIN_LEN_C) & w_filter;
  assign w_full   = (r_count == CW'(DESC_DEPTH)) & ~w_pop;
  assign w_end    = w_in_frame & bus.rx_frame_end;
  assign w_push   = w_end & w_good & ~w_ovr & ~w_full;
  assign w_abort  = w_in_frame & bus.rx_frame_start & ~bus.rx_frame_end;
  assign w_drop   = (w_end & w_good & (w_ovr | w_full)) | w_abort;
  // Rejected or aborted frames hand their buffer space back.
  assign w_wptr_after = ((w_end & ~w_push) | w_abort) ? r_fstart : w_wptr_inc;

  // Frame reception state: write pointer, frame start, byte count, header.
  always_ff @(posedge econet_clk or posedge valid_rst) begin
    if (valid_rst) begin
      r_state  <= ST_IDLE;
      r_wptr   <= '0;
      r_fstart <= '0;
      r_cnt    <= '0;
      r_hdr    <= '0;
    end else begin
      r_wptr <= w_wptr_after;
      if (w_in_frame) begin
        r_cnt <= w_cnt_eff;
        r_hdr <= w_hdr_eff;
        if (w_hit) r_state <= ST_OVR;
      end
      if (w_end) r_state <= ST_IDLE;
      if (bus.rx_frame_start) begin
        r_fstart <= w_wptr_after;
        r_cnt    <= '0;
        r_hdr    <= '0;
        r_state  <= ST_RX;
      end
    end
  end

  // Descriptor queue pointers, occupancy and saturating drop counter.
  always_ff @(posedge econet_clk or posedge valid_rst) begin
    if (valid_rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_drop  <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + QAW'(1);
      if (w_pop)  r_rd <= w_rd_next;
      r_count <= r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  // Descriptor storage; only read through the valid-gated head outputs.
  always_ff @(posedge econet_clk) begin
    if (w_push) r_q[r_wr] <= {r_fstart, w_wptr_inc, w_cnt_eff, w_hdr_eff};
  end

  assign bus.buf_we       = w_we;
  assign bus.buf_waddr    = r_wptr;
  assign bus.buf_wdata    = w_we ? bus.rx_byte : 8'd0;
  assign bus.desc_valid   = w_valid;
  assign bus.desc_start   = w_valid ? w_head[DW-1 -: BUF_AW] : '0;
  assign bus.desc_end     = w_valid ? w_head[DW-1-BUF_AW -: BUF_AW] : '0;
  assign bus.desc_cnt     = w_valid ? w_head[48 +: CNTW] : '0;
  assign bus.desc_address = w_valid ? w_head[31:0] : 32'd0;
  assign bus.desc_scout   = w_valid ? {w_head[39:32], w_head[47:40]} : 16'd0;
  assign bus.desc_count   = r_count;
  assign bus.drop_count   = r_drop;
  assign bus.dbg_state    = r_state;
endmodule
